// File: rtl/counter_updown.sv
// Up/down modulo counter with parallel load, synchronous clear, wrap or
// saturate boundary mode, combinational terminal count for cascading.
module counter_updown #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  logic at_bound;

  // Boundary depends only on the current direction; no direction is stored.
  assign at_bound = up ? (Q == MAX_Q) : (Q == '0);
  assign tc       = en & ~load & ~clear & ~reset & at_bound;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      Q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (D > MAX_Q) begin
        Q   <= MAX_Q;
        ovf <= 1'b1;
      end else begin
        Q <= D;
      end
    end else if (en) begin
      if (at_bound) begin
        ovf <= 1'b1;
        if (sat) begin
          wrap <= 1'b0;
        end else begin
          Q    <= up ? '0 : MAX_Q;
          wrap <= 1'b1;
        end
      end else begin
        Q    <= up ? Q + WIDTH'(1) : Q - WIDTH'(1);
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
